// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM states, register offsets,
// STATUS bit positions and the BAUD_DIV clamp helper.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_e;

   localparam logic [3:0] OFF_RXDATA   = 4'h0;
   localparam logic [3:0] OFF_STATUS   = 4'h4;
   localparam logic [3:0] OFF_BAUD_DIV = 4'h8;
   localparam logic [3:0] OFF_CTRL     = 4'hC;

   localparam int STAT_DATA_READY = 0;
   localparam int STAT_FULL       = 1;
   localparam int STAT_OVERRUN    = 2;
   localparam int STAT_FRAME_ERR  = 3;
   localparam int STAT_BUSY       = 4;

   localparam logic [15:0] MIN_DIV = 16'd2;

   // A divisor below 2 would make the half-bit wait zero cycles long.
   function automatic logic [15:0] clamp_div(input logic [15:0] v);
      return (v < MIN_DIV) ? MIN_DIV : v;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received bytes; head is visible combinationally.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver with STATUS/BAUD_DIV/CTRL registers.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry receive FIFO; otherwise one holding byte.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic        write_enable,
   input  logic        read_enable,
   output logic [31:0] read_data,
   output logic        uart_rx_valid,
   input  logic        rx,
   output logic        rx_interrupt
);

   localparam logic [15:0] RESET_DIV = 16'(CLK_FREQ / BAUD_RATE);

   logic        rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] div_act_q, div_act_d;
   logic [15:0] baud_div_q, baud_div_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        rx_en_q, rx_en_d;
   logic        irq_en_q, irq_en_d;
   logic        overrun_q, overrun_d;
   logic        frame_err_q, frame_err_d;
   logic        irq_q, irq_d;
   logic        rd_prev_q;

   logic [3:0]  offset;
   logic [15:0] half_div;
   logic        rx_fall;
   logic        push_req, frame_err_set, overrun_set;
   logic        push_ok, pop_ok;
   logic        data_ready, full;
   logic [7:0]  head;
   logic        w1c_sel;
   logic [31:0] status_word;
   logic        unused_ok;

   assign offset        = addr[3:0];
   assign half_div      = {1'b0, div_act_q[15:1]};
   assign rx_fall       = rx_prev_q && !rx_sync_q;
   assign uart_rx_valid = read_enable;
   assign rx_interrupt  = irq_q;
   assign unused_ok     = ^{addr[31:4], write_data[31:16], 32'(FIFO_DEPTH)};

   // Two-flop synchronizer plus one extra stage for falling-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      div_act_d     = div_act_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      push_req      = 1'b0;
      frame_err_set = 1'b0;
      if (!rx_en_q) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rx_fall) begin
                  state_d   = ST_START;
                  cnt_d     = '0;
                  bit_cnt_d = '0;
                  div_act_d = baud_div_q;
               end
            end
            ST_START: begin
               if (cnt_q == half_div - 16'd1) begin
                  cnt_d   = '0;
                  state_d = rx_sync_q ? ST_IDLE : ST_DATA;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            ST_DATA: begin
               if (cnt_q == div_act_q - 16'd1) begin
                  cnt_d   = '0;
                  shift_d = {rx_sync_q, shift_q[7:1]};
                  if (bit_cnt_q == 3'd7) begin
                     state_d = ST_STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            ST_STOP: begin
               if (cnt_q == div_act_q - 16'd1) begin
                  cnt_d         = '0;
                  state_d       = ST_IDLE;
                  push_req      = rx_sync_q;
                  frame_err_set = !rx_sync_q;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Only the first cycle of a read strobe pops, so long strobes read once.
   assign pop_ok      = read_enable && !rd_prev_q && (offset == OFF_RXDATA) && data_ready;
   assign push_ok     = push_req && (!full || pop_ok);
   assign overrun_set = push_req && full && !pop_ok;
   assign w1c_sel     = write_enable && (offset == OFF_STATUS);

`ifdef UART_RX_FIFO_EN
   logic fifo_empty;

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_ok),
      .pop   (pop_ok),
      .din   (shift_q),
      .dout  (head),
      .full  (full),
      .empty (fifo_empty)
   );

   assign data_ready = !fifo_empty;
`else
   logic       hold_valid_q, hold_valid_d;
   logic [7:0] hold_q, hold_d;

   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_d       = hold_q;
      if (push_ok) begin
         hold_valid_d = 1'b1;
         hold_d       = shift_q;
      end else if (pop_ok) begin
         hold_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid_q <= 1'b0;
         hold_q       <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_q       <= hold_d;
      end
   end

   assign data_ready = hold_valid_q;
   assign full       = hold_valid_q;
   assign head       = hold_q;
`endif

   always_comb begin
      baud_div_d  = baud_div_q;
      rx_en_d     = rx_en_q;
      irq_en_d    = irq_en_q;
      if (write_enable && (offset == OFF_BAUD_DIV)) begin
         baud_div_d = clamp_div(write_data[15:0]);
      end
      if (write_enable && (offset == OFF_CTRL)) begin
         rx_en_d  = write_data[0];
         irq_en_d = write_data[1];
      end
      // A flag raised in the same cycle as its W1C clear stays set.
      overrun_d   = overrun_set   || (overrun_q   && !(w1c_sel && write_data[STAT_OVERRUN]));
      frame_err_d = frame_err_set || (frame_err_q && !(w1c_sel && write_data[STAT_FRAME_ERR]));
      irq_d       = irq_en_q && (data_ready || overrun_q || frame_err_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         div_act_q   <= RESET_DIV;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         baud_div_q  <= RESET_DIV;
         rx_en_q     <= 1'b1;
         irq_en_q    <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         irq_q       <= 1'b0;
         rd_prev_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         div_act_q   <= div_act_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         baud_div_q  <= baud_div_d;
         rx_en_q     <= rx_en_d;
         irq_en_q    <= irq_en_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         irq_q       <= irq_d;
         rd_prev_q   <= read_enable;
      end
   end

   always_comb begin
      status_word                  = '0;
      status_word[STAT_DATA_READY] = data_ready;
      status_word[STAT_FULL]       = full;
      status_word[STAT_OVERRUN]    = overrun_q;
      status_word[STAT_FRAME_ERR]  = frame_err_q;
      status_word[STAT_BUSY]       = (state_q != ST_IDLE);
   end

   always_comb begin
      read_data = '0;
      if (read_enable) begin
         case (offset)
            OFF_RXDATA:   read_data = data_ready ? {24'd0, head} : 32'd0;
            OFF_STATUS:   read_data = status_word;
            OFF_BAUD_DIV: read_data = {16'd0, baud_div_q};
            OFF_CTRL:     read_data = {30'd0, irq_en_q, rx_en_q};
            default:      read_data = '0;
         endcase
      end
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, reset baud; reset divisor = CLK_FREQ/BAUD_RATE (434), integer-truncated.
REQ-003 Parameter FIFO_DEPTH, default 8, power of two, receive FIFO entries (used only with UART_RX_FIFO_EN).
REQ-004 clk  in  1  single system clock, all logic rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 addr  in  32  full CPU data address; offset = addr[3:0].
REQ-007 write_data  in  32  store data.
REQ-008 write_enable  in  1  store strobe, pre-qualified by top-level address decode.
REQ-009 read_enable  in  1  load strobe, pre-qualified by address decode.
REQ-010 read_data  out  32  combinational register read data.
REQ-011 uart_rx_valid  out  1  high whenever read_enable is high.
REQ-012 rx  in  1  asynchronous serial input, idle high.
REQ-013 rx_interrupt  out  1  level interrupt to CPU.

Function
REQ-014 Register map: 0x0 RXDATA (RO, [7:0]), 0x4 STATUS, 0x8 BAUD_DIV ([15:0] RW), 0xC CTRL (bit0 rx_en, bit1 irq_en); unmapped offsets read 0, writes ignored.
REQ-015 STATUS: bit0 data_ready (not empty), bit1 full, bit2 overrun (sticky, W1C), bit3 frame_err (sticky, W1C), bit4 busy (FSM not IDLE); other bits 0.
REQ-016 rx passes a 2-flop synchronizer (reset to 1) before any use.
REQ-017 Frame 8N1, LSB first; FSM states IDLE, START, DATA, STOP.
REQ-018 IDLE->START on synchronized 1->0 transition while rx_en=1; bit counter cleared.
REQ-019 START: after BAUD_DIV/2 cycles sample; 0 -> DATA, 1 -> IDLE (false start, nothing pushed, no flag).
REQ-020 DATA: sample every BAUD_DIV cycles, shift in, after 8th sample -> STOP.
REQ-021 STOP: after BAUD_DIV cycles sample; 1 -> push byte; 0 -> set frame_err, discard byte; either case -> IDLE same cycle.
REQ-022 Push when full: byte dropped, overrun set, contents unchanged.
REQ-023 Pop occurs once per RXDATA read access, on the first cycle of read_enable (high now, low previous cycle); read_data shows head byte that cycle.
REQ-024 RXDATA read when empty returns 0, no pop, no flag.
REQ-025 Simultaneous push and pop: both performed, occupancy unchanged; push into full FIFO with simultaneous pop succeeds.
REQ-026 Sticky set and W1C clear in same cycle: set wins.
REQ-027 BAUD_DIV write takes effect at next frame start; values below 2 are forced to 2.
REQ-028 Clearing rx_en mid-frame aborts to IDLE, discarding the partial byte; stored data retained.
REQ-029 rx_interrupt = irq_en AND (data_ready OR overrun OR frame_err), registered, one-cycle latency.

Reset
REQ-030 On rst: FSM IDLE, FIFO empty, pointers 0, flags 0, BAUD_DIV = CLK_FREQ/BAUD_RATE, CTRL = 0x1, rx_interrupt 0, read_data 0 when not reading; a frame in progress is discarded.

Configuration
REQ-031 UART_RX_FIFO_EN defined: FIFO of FIFO_DEPTH entries, full = FIFO_DEPTH entries stored.
REQ-032 UART_RX_FIFO_EN undefined: single-byte holding register; full = data_ready; all other behaviour identical.

Structure
REQ-033 memory_map.vh gains UART_RX_BASE, UART_RX_SIZE, IS_UART_RX_MEM; register offsets and STATUS bit positions live in a shared uart_regs.vh used by uart and uart_rx.
REQ-034 Sub-module uart_rx_fifo (sync FIFO, push/pop/full/empty) instantiated only under UART_RX_FIFO_EN.

Verification
REQ-035 BAUD_DIV=16, send 0xA5 8N1 -> STATUS=0x01, RXDATA read returns 0xA5, then STATUS=0x00.
REQ-036 Low glitch of 4 cycles on rx -> no push, STATUS bit4 returns 0, no flags.
REQ-037 Send 0x3C with stop bit 0 -> frame_err set, FIFO empty; write STATUS 0x08 -> flag clears.
REQ-038 FIFO_EN, send 9 bytes 0x00..0x08 unread -> full=1, overrun=1, reads return 0x00..0x07 then empty.
REQ-039 irq_en=1, receive 0x55 -> rx_interrupt high one cycle after push; RXDATA read -> low next cycle.
REQ-040 Assert rst mid-DATA -> all outputs at reset values; next full frame 0x81 received correctly.
